id_ex_stage: RTL and testbench

- ID/EX pipeline register plus operand forwarding, directly upstream of the EX-stage adder/ALU.
- Captures decoded operands and control from ID, then resolves RAW hazards from the MEM and WB stages.
- Drives the A, B, ALUFun and Sign inputs of the ALU adder.
- Detects load-use hazards and requests an ID stall.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_fwd_mux.sv | 31 +++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: datapath widths and ALUFun encodings used by the EX stage.
package cpu_defs;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned ALUFUN_W = 6;

  // The bubble's alufun is also the ADD code; a bubble is harmless because regwrite=0.
  localparam logic [ALUFUN_W-1:0] ALUFUN_NOP = 6'b000000;
  localparam logic [ALUFUN_W-1:0] ALUFUN_ADD = 6'b000000;
  localparam logic [ALUFUN_W-1:0] ALUFUN_SUB = 6'b000001;
  localparam logic [ALUFUN_W-1:0] ALUFUN_AND = 6'b011000;
  localparam logic [ALUFUN_W-1:0] ALUFUN_OR  = 6'b011110;
  localparam logic [ALUFUN_W-1:0] ALUFUN_XOR = 6'b010110;
  localparam logic [ALUFUN_W-1:0] ALUFUN_NOR = 6'b010001;
  localparam logic [ALUFUN_W-1:0] ALUFUN_A   = 6'b011010;
  localparam logic [ALUFUN_W-1:0] ALUFUN_SLL = 6'b100000;
  localparam logic [ALUFUN_W-1:0] ALUFUN_SRL = 6'b100001;
  localparam logic [ALUFUN_W-1:0] ALUFUN_SRA = 6'b100011;
  localparam logic [ALUFUN_W-1:0] ALUFUN_EQ  = 6'b110011;
  localparam logic [ALUFUN_W-1:0] ALUFUN_NEQ = 6'b110001;
  localparam logic [ALUFUN_W-1:0] ALUFUN_LT  = 6'b110101;
  localparam logic [ALUFUN_W-1:0] ALUFUN_LEZ = 6'b111101;
  localparam logic [ALUFUN_W-1:0] ALUFUN_LTZ = 6'b111011;
  localparam logic [ALUFUN_W-1:0] ALUFUN_GTZ = 6'b111111;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result beats the register value; r0 never forwards.
module fwd_mux
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W = cpu_defs::DATA_W,
  parameter int unsigned REG_AW = cpu_defs::REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] value,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd_addr != '0) && (mem_rd_addr == addr);
  assign wb_hit  = wb_regwrite  && (wb_rd_addr  != '0) && (wb_rd_addr  == addr);

  always_comb begin
    fwd = value;
    if (mem_hit)     fwd = mem_result;
    else if (wb_hit) fwd = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU operand selection and load-use detection.
module id_ex_stage
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W = cpu_defs::DATA_W,
  parameter int unsigned REG_AW = cpu_defs::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic              id_memread,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [5:0]        ex_alufun,
  output logic              ex_sign,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              load_use
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              alusrc1;
    logic              alusrc2;
    logic [5:0]        alufun;
    logic              sign;
    logic              memread;
    logic              regwrite;
    logic [REG_AW-1:0] rd_addr;
  } ex_reg_t;

  ex_reg_t q;
  ex_reg_t d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] rs_refresh;
  logic [DATA_W-1:0] rt_refresh;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr(q.rs_addr), .value(q.rs_data),
    .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd(rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr(q.rt_addr), .value(q.rt_data),
    .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd(rt_fwd)
  );

  // With the MEM path disabled the mux yields the held value refreshed by a retiring WB write.
  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_refresh_rs (
    .addr(q.rs_addr), .value(q.rs_data),
    .mem_regwrite(1'b0), .mem_rd_addr('0), .mem_result('0),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd(rs_refresh)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_refresh_rt (
    .addr(q.rt_addr), .value(q.rt_data),
    .mem_regwrite(1'b0), .mem_rd_addr('0), .mem_result('0),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd(rt_refresh)
  );

  always_comb begin
    d = q;
    if (flush) begin
      d        = '0;
      d.alufun = ALUFUN_NOP;
    end else if (stall) begin
      d.rs_data = rs_refresh;
      d.rt_data = rt_refresh;
    end else begin
      d.valid    = id_valid;
      d.rs_addr  = id_rs_addr;
      d.rt_addr  = id_rt_addr;
      d.rs_data  = id_rs_data;
      d.rt_data  = id_rt_data;
      d.imm      = id_imm;
      d.shamt    = id_shamt;
      d.alusrc1  = id_alusrc1;
      d.alusrc2  = id_alusrc2;
      d.alufun   = id_alufun;
      d.sign     = id_sign;
      d.memread  = id_memread;
      d.regwrite = id_regwrite;
      d.rd_addr  = id_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

  assign ex_valid      = q.valid;
  assign ex_A          = q.alusrc1 ? {{(DATA_W-5){1'b0}}, q.shamt} : rs_fwd;
  assign ex_B          = q.alusrc2 ? q.imm : rt_fwd;
  assign ex_alufun     = q.alufun;
  assign ex_sign       = q.sign;
  assign ex_store_data = rt_fwd;
  assign ex_regwrite   = q.regwrite;
  assign ex_memread    = q.memread;
  assign ex_rd_addr    = q.rd_addr;

  assign load_use = q.valid && q.memread && (q.rd_addr != '0) && id_valid &&
                    ((q.rd_addr == id_rs_addr) || (q.rd_addr == id_rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps, then random traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc1, id_alusrc2, id_sign, id_memread, id_regwrite;
  logic [5:0]  id_alufun;
  logic        stall, flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_sign, ex_regwrite, ex_memread, load_use;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [5:0]  ex_alufun;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_alufun(id_alufun), .id_sign(id_sign), .id_memread(id_memread),
    .id_regwrite(id_regwrite), .id_rd_addr(id_rd_addr),
    .stall(stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_alufun(ex_alufun),
    .ex_sign(ex_sign), .ex_store_data(ex_store_data), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd_addr(ex_rd_addr), .load_use(load_use)
  );

  // Behavioural model: the instruction currently sitting in EX.
  typedef struct {
    bit        valid, s1, s2, sign, mr, rw;
    bit [4:0]  rs, rt, rd, shamt;
    bit [31:0] rsd, rtd, imm;
    bit [5:0]  fun;
  } instr_t;

  instr_t m;

  function automatic instr_t empty_instr();
    instr_t e;
    e.valid = 0; e.s1 = 0; e.s2 = 0; e.sign = 0; e.mr = 0; e.rw = 0;
    e.rs = 0; e.rt = 0; e.rd = 0; e.shamt = 0; e.rsd = 0; e.rtd = 0; e.imm = 0; e.fun = 0;
    return e;
  endfunction

  function automatic bit wb_writes(bit [4:0] a);
    return wb_regwrite && wb_rd_addr != 0 && wb_rd_addr == a;
  endfunction

  function automatic bit [31:0] value_of(bit [4:0] a, bit [31:0] raw);
    if (mem_regwrite && mem_rd_addr != 0 && mem_rd_addr == a) return mem_result;
    if (wb_writes(a)) return wb_result;
    return raw;
  endfunction

  function automatic instr_t model_next();
    instr_t n;
    n = m;
    if (flush) n = empty_instr();
    else if (stall) begin
      if (wb_writes(m.rs)) n.rsd = wb_result;
      if (wb_writes(m.rt)) n.rtd = wb_result;
    end else begin
      n.valid = id_valid; n.rs = id_rs_addr; n.rt = id_rt_addr; n.rsd = id_rs_data;
      n.rtd = id_rt_data; n.imm = id_imm; n.shamt = id_shamt; n.s1 = id_alusrc1;
      n.s2 = id_alusrc2; n.fun = id_alufun; n.sign = id_sign; n.mr = id_memread;
      n.rw = id_regwrite; n.rd = id_rd_addr;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit [31:0] a, b, st;
    bit lu;
    st = value_of(m.rt, m.rtd);
    a  = m.s1 ? 32'(m.shamt) : value_of(m.rs, m.rsd);
    b  = m.s2 ? m.imm : st;
    lu = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs_addr || m.rd == id_rt_addr);
    chk({tag, ".valid"},    32'(ex_valid),    32'(m.valid));
    chk({tag, ".A"},        ex_A,             a);
    chk({tag, ".B"},        ex_B,             b);
    chk({tag, ".store"},    ex_store_data,    st);
    chk({tag, ".alufun"},   32'(ex_alufun),   32'(m.fun));
    chk({tag, ".sign"},     32'(ex_sign),     32'(m.sign));
    chk({tag, ".regwrite"}, 32'(ex_regwrite), 32'(m.rw));
    chk({tag, ".memread"},  32'(ex_memread),  32'(m.mr));
    chk({tag, ".rd"},       32'(ex_rd_addr),  32'(m.rd));
    chk({tag, ".load_use"}, 32'(load_use),    32'(lu));
  endtask

  // Advance one clock; inputs are sampled by the model exactly as they stand before the edge.
  task automatic tick();
    instr_t n;
    n = reset ? model_next() : empty_instr();
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc1 = 0; id_alusrc2 = 0;
    id_alufun = 0; id_sign = 0; id_memread = 0; id_regwrite = 0;
    stall = 0; flush = 0;
    mem_regwrite = 0; mem_rd_addr = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd_addr = 0; wb_result = 0;
  endtask

  initial begin
    m = empty_instr();
    reset = 0;
    clear_inputs();
    id_valid = 1; id_alufun = 6'h2A; id_rs_data = 32'hDEAD; id_rd_addr = 5'd7; id_regwrite = 1;

    // 1. Reset state, including across a clock edge with live ID inputs
    #2;
    chk("rst.valid", 32'(ex_valid), 0);
    chk("rst.alufun", 32'(ex_alufun), 0);
    chk("rst.A", ex_A, 0);
    tick();
    chk("rst_edge.valid", 32'(ex_valid), 0);
    chk("rst_edge.rd", 32'(ex_rd_addr), 0);
    chk("rst_edge.load_use", 32'(load_use), 0);
    check_model("rst");
    reset = 1;
    clear_inputs();

    // 1. Capture with one-cycle latency
    id_valid = 1; id_rs_addr = 3; id_rs_data = 5; id_rt_addr = 4; id_rt_data = 7;
    id_rd_addr = 9; id_regwrite = 1; id_alufun = 6'h00;
    tick();
    chk("cap.A", ex_A, 32'd5);
    chk("cap.B", ex_B, 32'd7);
    chk("cap.valid", 32'(ex_valid), 1);
    check_model("cap");

    // 2. Forwarding priority on held rs=3
    stall = 1; id_valid = 0;
    mem_regwrite = 1; mem_rd_addr = 3; mem_result = 32'h11;
    wb_regwrite = 1; wb_rd_addr = 3; wb_result = 32'h22;
    #1 chk("fwd.mem", ex_A, 32'h11);
    mem_regwrite = 0;
    #1 chk("fwd.wb", ex_A, 32'h22);
    wb_regwrite = 0; mem_regwrite = 1; mem_rd_addr = 0;
    #1 chk("fwd.r0", ex_A, 32'd5);
    check_model("fwd");
    mem_regwrite = 0;

    // 3. WB write to rt during a stall survives the stall
    wb_regwrite = 1; wb_rd_addr = 4; wb_result = 32'h99;
    tick();
    wb_regwrite = 0;
    #1 chk("stall1.B", ex_B, 32'h99);
    tick();
    chk("stall2.B", ex_B, 32'h99);
    tick();
    chk("stall3.B", ex_B, 32'h99);
    chk("stall3.A", ex_A, 32'd5);
    check_model("stall");

    // 4. Flush beats stall
    stall = 0; id_valid = 1; id_alufun = 6'h21; id_regwrite = 1; id_rd_addr = 12;
    tick();
    chk("pre_flush.alufun", 32'(ex_alufun), 32'h21);
    stall = 1; flush = 1;
    tick();
    chk("flush.valid", 32'(ex_valid), 0);
    chk("flush.regwrite", 32'(ex_regwrite), 0);
    chk("flush.alufun", 32'(ex_alufun), 0);
    check_model("flush");
    stall = 0; flush = 0;

    // 5. Load-use detection
    clear_inputs();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd_addr = 8;
    tick();
    id_memread = 0; id_rs_addr = 1; id_rt_addr = 8;
    #1 chk("lu.hit", 32'(load_use), 1);
    check_model("lu_hit");
    id_memread = 1; id_rd_addr = 0;
    tick();
    id_rs_addr = 0; id_rt_addr = 0;
    #1 chk("lu.r0", 32'(load_use), 0);
    check_model("lu_r0");

    // 6. Operand selection with shamt/immediate, store data still forwarded
    clear_inputs();
    id_valid = 1; id_alusrc1 = 1; id_shamt = 31; id_alusrc2 = 1; id_imm = 32'hFFFF_FFFC;
    id_rt_addr = 6; id_rt_data = 32'h1234; id_rs_addr = 2; id_rs_data = 32'h77;
    tick();
    mem_regwrite = 1; mem_rd_addr = 6; mem_result = 32'h55;
    #1;
    chk("sel.A", ex_A, 32'h1F);
    chk("sel.B", ex_B, 32'hFFFF_FFFC);
    chk("sel.store", ex_store_data, 32'h55);
    check_model("sel");

    // Random traffic, with occasional asynchronous reset during stall/flush
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom); id_rs_addr = 5'($urandom_range(0, 7));
      id_rt_addr = 5'($urandom_range(0, 7)); id_rd_addr = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alusrc1 = ($urandom_range(0, 3) == 0);
      id_alusrc2 = ($urandom_range(0, 3) == 0); id_alufun = 6'($urandom);
      id_sign = 1'($urandom); id_memread = 1'($urandom); id_regwrite = 1'($urandom);
      stall = ($urandom_range(0, 2) == 0); flush = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_regwrite = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #1 check_model("rnd_comb");
      if ($urandom_range(0, 31) == 0) begin
        stall = 1;
        reset = 0;
        m = empty_instr();
        #1 check_model("rnd_async_rst");
        tick();
        check_model("rnd_rst_edge");
        reset = 1;
      end
      tick();
      check_model("rnd_seq");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
